param_cpu: RTL and testbench

PARAM_CPU -- requirements
Module: param_cpu

---
 rtl/param_cpu.sv | 153 +++++++++++++++
 tb/tb_param_cpu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cpu.sv
// Parameterised multi-cycle accumulator-free CPU: IDLE -> EXEC/CLR -> DONE.
// Register file is internal; DISPLAY copies a register to the LCD port.
module param_cpu #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 16,
  parameter int IMM_W  = 7
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              instr_valid,
  input  logic [2+2*$clog2(REG_N)+IMM_W:0]  instr,
  output logic                              instr_ready,
  output logic                              done,
  output logic [DATA_W-1:0]                 lcd_data,
  output logic                              lcd_valid,
  output logic                              zero_flag,
  output logic                              ovf_flag
);

  localparam int RA_W    = $clog2(REG_N);
  localparam int INSTR_W = 3 + 2*RA_W + IMM_W;
  localparam int PW      = 2*DATA_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] CLR  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DISP = 3'b111;

  logic [1:0]         state;
  logic [INSTR_W-1:0] ir;
  logic [RA_W-1:0]    clr_cnt;
  logic [DATA_W-1:0]  regs [REG_N];

  logic [2:0]        op;
  logic [RA_W-1:0]   dest;
  logic [RA_W-1:0]   src1;
  logic [RA_W-1:0]   src2;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] opd2;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [PW-1:0]     prod;
  logic [DATA_W:0]   prod_hi;
  logic              add_ovf;
  logic              sub_ovf;
  logic              mul_ovf;
  logic [DATA_W-1:0] result;
  logic              res_ovf;
  logic              wr_en;

  assign op     = ir[INSTR_W-1 -: 3];
  assign dest   = ir[INSTR_W-4 -: RA_W];
  assign src1   = ir[INSTR_W-4-RA_W -: RA_W];
  assign src2   = ir[IMM_W-1 -: RA_W];
  assign imm    = ir[IMM_W-1:0];
  assign imm_sx = DATA_W'($signed(imm));

  assign a    = regs[src1];
  assign b    = regs[src2];
  assign opd2 = (op == OP_ADD || op == OP_SUB) ? b : imm_sx;
  assign sum  = a + opd2;
  assign diff = a - opd2;

  assign add_ovf = (a[DATA_W-1] == opd2[DATA_W-1]) &&
                   (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf = (a[DATA_W-1] != opd2[DATA_W-1]) &&
                   (diff[DATA_W-1] != a[DATA_W-1]);

  // Full signed product; overflow unless the top DATA_W+1 bits agree.
  assign prod = {{DATA_W{a[DATA_W-1]}}, a} *
                {{DATA_W{imm_sx[DATA_W-1]}}, imm_sx};
  assign prod_hi = prod[PW-1:DATA_W-1];
  assign mul_ovf = !((&prod_hi) || !(|prod_hi));

  always_comb begin
    result  = '0;
    res_ovf = 1'b0;
    wr_en   = 1'b1;
    unique case (1'b1)
      (op == OP_LOAD): result = imm_sx;
      (op == OP_ADD),
      (op == OP_ADDI): begin
        result  = sum;
        res_ovf = add_ovf;
      end
      (op == OP_SUB),
      (op == OP_SUBI): begin
        result  = diff;
        res_ovf = sub_ovf;
      end
      (op == OP_MUL): begin
        result  = prod[DATA_W-1:0];
        res_ovf = mul_ovf;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ir        <= '0;
      clr_cnt   <= '0;
      lcd_data  <= '0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          ir    <= instr;
          state <= (instr[INSTR_W-1 -: 3] == OP_CLR) ? CLR : EXEC;
        end
        EXEC: begin
          state <= DONE;
          if (wr_en) begin
            regs[dest] <= result;
            zero_flag  <= (result == '0);
            ovf_flag   <= res_ovf;
          end
          if (op == OP_DISP) lcd_data <= a;
        end
        CLR: begin
          regs[clr_cnt] <= '0;
          clr_cnt       <= clr_cnt + 1'b1;
          if (clr_cnt == RA_W'(REG_N-1)) begin
            state     <= DONE;
            zero_flag <= 1'b1;
            ovf_flag  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign done        = (state == DONE);
  assign lcd_valid   = (state == DONE) && (op == OP_DISP);

endmodule

// File: tb/tb_param_cpu.sv
// Bench for param_cpu: default and 8-bit builds side by side,
// checked against an integer-arithmetic reference model.
module tb_param_cpu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        v0, v1;
  logic [17:0] i0;
  logic [13:0] i1;
  logic        rd0, rd1, d0, d1, lv0, lv1, z0, z1, o0, o1;
  logic [15:0] l0;
  logic [7:0]  l1;

  param_cpu u0 (
    .clk(clk), .reset(reset), .instr_valid(v0), .instr(i0),
    .instr_ready(rd0), .done(d0), .lcd_data(l0), .lcd_valid(lv0),
    .zero_flag(z0), .ovf_flag(o0)
  );

  param_cpu #(.DATA_W(8), .REG_N(8), .IMM_W(5)) u1 (
    .clk(clk), .reset(reset), .instr_valid(v1), .instr(i1),
    .instr_ready(rd1), .done(d1), .lcd_data(l1), .lcd_valid(lv1),
    .zero_flag(z1), .ovf_flag(o1)
  );

  int checks = 0;
  int errors = 0;

  longint mreg [2][16];
  longint mlcd [2];
  bit     mz   [2];
  bit     mo   [2];

  function automatic int dw(int s); return s ? 8 : 16; endfunction
  function automatic int nr(int s); return s ? 8 : 16; endfunction
  function automatic int iw(int s); return s ? 5 : 7;  endfunction
  function automatic int ra(int s); return s ? 3 : 4;  endfunction

  function automatic longint sx(longint v, int w);
    longint m = (longint'(1) << w) - 1;
    longint r = v & m;
    if (r >= (longint'(1) << (w-1))) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic logic [63:0] enc(int s, int op, int d, int s1, int imm);
    longint w;
    w = (longint'(op) << (2*ra(s)+iw(s))) |
        (longint'(d)  << (ra(s)+iw(s)))   |
        (longint'(s1) << iw(s))           |
        (longint'(imm) & ((longint'(1) << iw(s)) - 1));
    return w;
  endfunction

  function automatic longint g_rdy(int s);  return s ? longint'(rd1) : longint'(rd0); endfunction
  function automatic longint g_done(int s); return s ? longint'(d1)  : longint'(d0);  endfunction
  function automatic longint g_lv(int s);   return s ? longint'(lv1) : longint'(lv0); endfunction
  function automatic longint g_z(int s);    return s ? longint'(z1)  : longint'(z0);  endfunction
  function automatic longint g_o(int s);    return s ? longint'(o1)  : longint'(o0);  endfunction
  function automatic longint g_lcd(int s);  return s ? longint'(l1)  : longint'(l0);  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input bit v, input logic [63:0] w);
    if (s != 0) begin
      v1 = v;
      i1 = w[13:0];
    end else begin
      v0 = v;
      i0 = w[17:0];
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 16; r++) mreg[s][r] = 0;
      mlcd[s] = 0;
      mz[s]   = 0;
      mo[s]   = 0;
    end
  endtask

  task automatic check_idle_reset();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("s%0d rst ready", s), g_rdy(s), 1);
      chk($sformatf("s%0d rst done", s), g_done(s), 0);
      chk($sformatf("s%0d rst lcd", s), g_lcd(s), 0);
      chk($sformatf("s%0d rst lcd_valid", s), g_lv(s), 0);
      chk($sformatf("s%0d rst zero", s), g_z(s), 0);
      chk($sformatf("s%0d rst ovf", s), g_o(s), 0);
    end
  endtask

  task automatic issue(input int s, input logic [63:0] w, input bit hold,
                       input logic [63:0] hw, output int lat);
    @(negedge clk);
    chk($sformatf("s%0d ready", s), g_rdy(s), 1);
    drive(s, 1'b1, w);
    @(posedge clk);
    #1;
    if (hold) drive(s, 1'b1, hw);
    else drive(s, 1'b0, w);
    lat = -1;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (g_done(s) == 1) begin
        lat = n;
        break;
      end
      if (hold) chk($sformatf("s%0d ready_low", s), g_rdy(s), 0);
    end
    if (lat < 0) chk($sformatf("s%0d done_timeout", s), 0, 1);
  endtask

  task automatic retire(input int s, input int op, input int d,
                        input int s1, input int imm, input int lat);
    int     w   = dw(s);
    int     f   = imm & ((1 << iw(s)) - 1);
    int     s2  = f >> (iw(s) - ra(s));
    longint lim = longint'(1) << (w-1);
    longint a, b, im, r;
    string  t;
    t  = $sformatf("s%0d op%0d", s, op);
    a  = sx(mreg[s][s1], w);
    b  = sx(mreg[s][s2], w);
    im = sx(f, iw(s));
    chk({t, " latency"}, lat, (op == 6) ? nr(s) + 1 : 2);
    case (op)
      0: r = im;
      1: r = a + b;
      2: r = a + im;
      3: r = a - b;
      4: r = a - im;
      5: r = a * im;
      default: r = 0;
    endcase
    if (op <= 5) begin
      mreg[s][d] = r & ((longint'(1) << w) - 1);
      mz[s] = (mreg[s][d] == 0);
      mo[s] = (op != 0) && (r < -lim || r >= lim);
    end else if (op == 6) begin
      for (int i = 0; i < 16; i++) mreg[s][i] = 0;
      mz[s] = 1;
      mo[s] = 0;
    end else begin
      mlcd[s] = mreg[s][s1];
    end
    chk({t, " lcd_valid"}, g_lv(s), (op == 7) ? 1 : 0);
    chk({t, " lcd_data"}, g_lcd(s), mlcd[s]);
    chk({t, " zero"}, g_z(s), longint'(mz[s]));
    chk({t, " ovf"}, g_o(s), longint'(mo[s]));
  endtask

  task automatic run(input int s, input int op, input int d,
                     input int s1, input int imm);
    int lat;
    issue(s, enc(s, op, d, s1, imm), 1'b0, 64'd0, lat);
    retire(s, op, d, s1, imm, lat);
    @(negedge clk);
    chk($sformatf("s%0d done_pulse", s), g_done(s), 0);
    chk($sformatf("s%0d lcd_valid_pulse", s), g_lv(s), 0);
  endtask

  task automatic show_all(input int s);
    for (int r = 0; r < nr(s); r++) run(s, 7, 0, r, 0);
  endtask

  initial begin
    int lat;
    v0 = 0; v1 = 0; i0 = '0; i1 = '0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_idle_reset();
    reset = 1'b0;

    for (int s = 0; s < 2; s++) begin
      int big = s ? -16 : -64;
      run(s, 0, 1, 0, 5);
      run(s, 7, 0, 1, 0);
      run(s, 0, 2, 0, -3);
      run(s, 1, 3, 1, 2 << (iw(s) - ra(s)));
      run(s, 7, 0, 2, 0);
      run(s, 7, 0, 3, 0);
      run(s, 0, 1, 0, big);
      run(s, 5, 2, 1, big);
      run(s, 7, 0, 2, 0);
      run(s, 5, 3, 2, big);
      run(s, 7, 0, 3, 0);
      run(s, 3, 3, 3, 3 << (iw(s) - ra(s)));
      run(s, 4, 1, 1, 1);
    end

    // CLEAR while the next instruction waits with valid held high.
    run(0, 0, 5, 0, 9);
    issue(0, enc(0, 6, 0, 0, 0), 1'b1, enc(0, 7, 0, 5, 0), lat);
    retire(0, 6, 0, 0, 0, lat);
    run(0, 7, 0, 5, 0);
    show_all(0);
    run(1, 6, 0, 0, 0);
    show_all(1);

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 40; k++) begin
        int op  = int'($urandom_range(0, 7));
        int d   = int'($urandom_range(0, nr(s) - 1));
        int s1  = int'($urandom_range(0, nr(s) - 1));
        int imm = int'($urandom_range(0, (1 << iw(s)) - 1));
        if (op == 6 && $urandom_range(0, 3) != 0) op = 7;
        run(s, op, d, s1, imm);
      end
      show_all(s);
    end

    run(0, 0, 2, 0, 17);
    @(negedge clk);
    drive(0, 1'b1, enc(0, 6, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(0, 1'b0, 64'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_idle_reset();
    run(0, 0, 1, 0, 5);
    run(0, 7, 0, 1, 0);
    run(0, 7, 0, 2, 0);
    run(1, 7, 0, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
